// File: rtl/ram_weights_pingpong_ctrl.sv
// ram_weights_pingpong_ctrl
//   Ping-pong sequencer for two single-port weight RAM banks. A DMA stream
//   fills one bank while the other bank is replayed to the PE array.
//   Each stored block is replayed s_repeats times (0 counts as 1).
//   RAM read latency is tracked by a valid/last shift register. Under
//   downstream backpressure the read bank and that shift register both
//   freeze, so each word leaves exactly once.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   s_data/s_valid/s_ready/s_last/s_repeats
//                  write stream from the DMA; s_repeats is taken on the
//                  first beat of a block
//   ram_en/ram_we/ram_addr/ram_di/ram_dout
//                  per-bank RAM port. Bank b uses bit b and slice
//                  [b*W +: W] of each bus.
//   m_data/m_valid/m_ready/m_last
//                  weight stream to the PE array; m_last marks the final
//                  word of the final replay
//   busy           per-bank occupied flag
module ram_weights_pingpong_ctrl #(
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 64,
    parameter int LATENCY    = 3,
    parameter int REP_BITS   = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [REP_BITS-1:0]     s_repeats,
    output logic [1:0]              ram_en,
    output logic [1:0]              ram_we,
    output logic [2*ADDR_WIDTH-1:0] ram_addr,
    output logic [2*WIDTH-1:0]      ram_di,
    input  logic [2*WIDTH-1:0]      ram_dout,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [1:0]              busy
);

    typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} bank_state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH-1);

    bank_state_t             state_q [2];
    bank_state_t             state_d [2];
    logic                    run_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [ADDR_WIDTH:0]     wcnt_q;
    logic [ADDR_WIDTH:0]     raddr_q;
    logic [REP_BITS-1:0]     rep_q;
    logic                    issue_done_q;
    logic [ADDR_WIDTH:0]     count_q [2];
    logic [REP_BITS-1:0]     reps_q [2];
    logic [LATENCY-1:0]      vld_p;
    logic [LATENCY-1:0]      last_p;

    logic                    wr_acc;
    logic                    wr_first;
    logic                    wr_end;
    logic                    stall;
    logic                    issue;
    logic                    rd_wrap;
    logic                    rd_final;
    logic                    rd_done;
    logic [REP_BITS-1:0]     rd_reps;
    logic [1:0]              rd_start;

    // run_q keeps s_ready low while in reset, so every output reads 0 there.
    assign s_ready  = run_q && (state_q[wr_ptr_q] == EMPTY || state_q[wr_ptr_q] == FILL);
    assign wr_acc   = s_valid && s_ready;
    assign wr_first = wr_acc && (state_q[wr_ptr_q] == EMPTY);
    assign wr_end   = wr_acc && (s_last || wcnt_q == LAST_ADDR);

    assign m_valid  = vld_p[LATENCY-1];
    assign m_last   = last_p[LATENCY-1];
    assign m_data   = !m_valid ? '0 :
                      (rd_ptr_q ? ram_dout[2*WIDTH-1:WIDTH] : ram_dout[WIDTH-1:0]);

    assign stall    = m_valid && !m_ready;
    assign rd_done  = m_valid && m_ready && m_last;
    assign rd_reps  = (reps_q[rd_ptr_q] == '0) ? REP_BITS'(1) : reps_q[rd_ptr_q];
    assign rd_wrap  = (raddr_q == count_q[rd_ptr_q] - 1'b1);
    assign rd_final = rd_wrap && (rep_q == rd_reps - 1'b1);
    assign issue    = (state_q[rd_ptr_q] == READ) && !issue_done_q && !stall;

    // Bank FSMs. A FULL bank starts reading when the reader already points at
    // it, or when the other bank hands off its last word this very cycle,
    // which keeps the gap between back-to-back blocks at LATENCY cycles.
    always_comb begin
        state_d  = state_q;
        rd_start = '0;
        for (int b = 0; b < 2; b++) begin
            rd_start[b] = (state_q[b] == FULL) && ((rd_ptr_q == 1'(b)) || rd_done);
            case (state_q[b])
                EMPTY: if (wr_acc && wr_ptr_q == 1'(b)) state_d[b] = wr_end ? FULL : FILL;
                FILL:  if (wr_end && wr_ptr_q == 1'(b)) state_d[b] = FULL;
                FULL:  if (rd_start[b]) state_d[b] = READ;
                READ:  if (rd_done && rd_ptr_q == 1'(b)) state_d[b] = EMPTY;
                default: state_d[b] = EMPTY;
            endcase
        end
    end

    // RAM port drive. The read bank stays enabled through the drain cycles
    // so its output pipeline keeps pace with vld_p.
    always_comb begin
        ram_en   = '0;
        ram_we   = '0;
        ram_addr = '0;
        ram_di   = '0;
        busy     = '0;
        for (int b = 0; b < 2; b++) begin
            busy[b] = (state_q[b] != EMPTY);
            if (wr_acc && wr_ptr_q == 1'(b)) begin
                ram_en[b]                               = 1'b1;
                ram_we[b]                               = 1'b1;
                ram_addr[b*ADDR_WIDTH +: ADDR_WIDTH]    = wcnt_q[ADDR_WIDTH-1:0];
                ram_di[b*WIDTH +: WIDTH]                = s_data;
            end else if (state_q[b] == READ) begin
                ram_en[b]                               = !stall;
                ram_addr[b*ADDR_WIDTH +: ADDR_WIDTH]    = raddr_q[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q[0]   <= EMPTY;
            state_q[1]   <= EMPTY;
            run_q        <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wcnt_q       <= '0;
            raddr_q      <= '0;
            rep_q        <= '0;
            issue_done_q <= 1'b0;
            vld_p        <= '0;
            last_p       <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;

            if (wr_acc) begin
                if (wr_end) begin
                    wcnt_q   <= '0;
                    wr_ptr_q <= !wr_ptr_q;
                end else begin
                    wcnt_q   <= wcnt_q + 1'b1;
                end
            end

            if (rd_done) rd_ptr_q <= !rd_ptr_q;

            if (|rd_start) begin
                raddr_q      <= '0;
                rep_q        <= '0;
                issue_done_q <= 1'b0;
            end else if (issue) begin
                if (rd_final) begin
                    issue_done_q <= 1'b1;
                end else if (rd_wrap) begin
                    raddr_q <= '0;
                    rep_q   <= rep_q + 1'b1;
                end else begin
                    raddr_q <= raddr_q + 1'b1;
                end
            end

            // Read pipe: stage i mirrors the bank's output register i.
            if (!stall) begin
                vld_p[0]  <= issue;
                last_p[0] <= issue && rd_final;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_p[i]  <= vld_p[i-1];
                    last_p[i] <= last_p[i-1];
                end
            end
        end
    end

    // Block descriptors; always written before the bank can be read.
    always_ff @(posedge clk) begin
        if (wr_first) reps_q[wr_ptr_q]  <= s_repeats;
        if (wr_end)   count_q[wr_ptr_q] <= wcnt_q + 1'b1;
    end

endmodule

// File: tb/tb_ram_weights_pingpong_ctrl.sv
// Testbench for ram_weights_pingpong_ctrl: behavioural RAM banks with an
// en-gated read pipeline, directed block stimulus, and a scoreboard monitor
// that pops expected words on every output handshake.
module tb_ram_weights_pingpong_ctrl;

    localparam int DEPTH    = 32;
    localparam int WIDTH    = 16;
    localparam int LATENCY  = 3;
    localparam int REP_BITS = 4;
    localparam int AW       = $clog2(DEPTH);

    logic                clk;
    logic                rstn;
    logic [WIDTH-1:0]    s_data;
    logic                s_valid;
    logic                s_ready;
    logic                s_last;
    logic [REP_BITS-1:0] s_repeats;
    logic [1:0]          ram_en;
    logic [1:0]          ram_we;
    logic [2*AW-1:0]     ram_addr;
    logic [2*WIDTH-1:0]  ram_di;
    logic [2*WIDTH-1:0]  ram_dout;
    logic [WIDTH-1:0]    m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic [1:0]          busy;

    ram_weights_pingpong_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .REP_BITS(REP_BITS)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_repeats(s_repeats),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port banks: read pipeline advances only when en=1.
    logic [WIDTH-1:0] mem  [2][DEPTH];
    logic [WIDTH-1:0] pipe [2][LATENCY];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (ram_en[b]) begin
                if (ram_we[b]) mem[b][ram_addr[b*AW +: AW]] <= ram_di[b*WIDTH +: WIDTH];
                pipe[b][0] <= mem[b][ram_addr[b*AW +: AW]];
                for (int i = 1; i < LATENCY; i++) pipe[b][i] <= pipe[b][i-1];
            end
        end
    end
    assign ram_dout = {pipe[1][LATENCY-1], pipe[0][LATENCY-1]};

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] q [$];   // {last, data}
    int  mode    = 0;        // 0: m_ready=1, 1: pattern 1,0,0 repeating
    bit  gap_chk = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // m_ready driver
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                m_ready = 1'b1;
            end else begin
                m_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        bit             rdb, stl, seen;
        logic [WIDTH-1:0] stl_d;
        logic           stl_l;
        int             gap;
        logic [WIDTH:0] e;
        rdb = 0; stl = 0; seen = 0; gap = 0; stl_d = '0; stl_l = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rdb = 0; stl = 0; seen = 0; gap = 0;
            end else begin
                if (stl) begin
                    chk(m_valid == 1'b1, "stall_valid_hold", m_valid, 1);
                    chk(m_data == stl_d, "stall_data_hold", m_data, stl_d);
                    chk(m_last == stl_l, "stall_last_hold", m_last, stl_l);
                end
                if (m_valid && !m_ready) begin
                    chk(ram_en[rdb] == 1'b0, "stall_ram_en", ram_en[rdb], 0);
                    stl = 1; stl_d = m_data; stl_l = m_last;
                end else begin
                    stl = 0;
                end
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        chk(0, "unexpected_word", m_data, 0);
                    end else begin
                        e = q.pop_front();
                        chk(m_data == e[WIDTH-1:0], "m_data", m_data, e[WIDTH-1:0]);
                        chk(m_last == e[WIDTH], "m_last", m_last, e[WIDTH]);
                    end
                    if (m_last) rdb = ~rdb;
                end
                if (!gap_chk) begin
                    seen = 0; gap = 0;
                end else if (m_valid) begin
                    if (seen && gap > 0) chk(gap <= LATENCY, "block_gap", gap, LATENCY);
                    seen = 1; gap = 0;
                end else if (seen) begin
                    gap++;
                end
            end
        end
    end

    task automatic write_block(input logic [WIDTH-1:0] base, input int n, input bit use_last,
                               input logic [REP_BITS-1:0] reps);
        int  r_eff;
        bit  acc;
        r_eff = (reps == 0) ? 1 : int'(reps);
        for (int r = 0; r < r_eff; r++)
            for (int i = 0; i < n; i++)
                q.push_back({(r == r_eff-1) && (i == n-1), base + WIDTH'(i)});
        for (int i = 0; i < n; i++) begin
            s_valid   = 1'b1;
            s_data    = base + WIDTH'(i);
            s_last    = use_last && (i == n-1);
            // Only the first beat's repeat count may matter.
            s_repeats = (i == 0) ? reps : reps + 4'd3;
            acc = 0;
            for (int w = 0; w < 400 && !acc; w++) begin
                @(negedge clk);
                if (s_ready) acc = 1;
                else chk(busy == 2'b11, "s_ready_drop_busy", busy, 3);
                @(posedge clk);
                #1;
            end
            if (!acc) chk(0, "write_timeout", i, n);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 0;
        for (int c = 0; c < bound && !done; c++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1;
        end
        if (!done) chk(0, "drain_timeout", q.size(), 0);
        @(posedge clk);
        @(negedge clk);
        chk(busy == 2'b00, "busy_after_drain", busy, 0);
        chk(m_valid == 1'b0, "idle_m_valid", m_valid, 0);
        repeat (LATENCY + 2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, k_rd;
        bit hit;
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_repeats = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(s_ready == 1'b0, "reset_s_ready", s_ready, 0);
        chk(m_valid == 1'b0, "reset_m_valid", m_valid, 0);
        chk(ram_en == 2'b00, "reset_ram_en", ram_en, 0);
        chk(busy == 2'b00, "reset_busy", busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(s_ready == 1'b1, "post_reset_s_ready", s_ready, 1);

        // 1: 4 words x2 repeats, m_ready=1, latency from READ entry
        mode = 0;
        write_block(16'h00A0, 4, 1, 4'd2);
        k = 0; k_rd = 0; hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            k++;
            if (k_rd == 0 && ram_en[0] && !ram_we[0]) k_rd = k;
            if (m_valid) hit = 1;
        end
        chk(k_rd == 2, "read_start_cycle", k_rd, 2);
        chk(hit && (k - k_rd == LATENCY), "first_valid_latency", k - k_rd, LATENCY);
        @(posedge clk); #1;
        wait_drain(100);

        // 2: same block with m_ready pattern 1,0,0
        mode = 1;
        write_block(16'h00A0, 4, 1, 4'd2);
        wait_drain(300);
        mode = 0;
        @(posedge clk); #1;

        // 3: three 16-word blocks back to back
        gap_chk = 1;
        write_block(16'h1000, 16, 1, 4'd1);
        write_block(16'h2000, 16, 1, 4'd1);
        write_block(16'h3000, 16, 1, 4'd1);
        wait_drain(300);
        gap_chk = 0;

        // 5: repeats=0 behaves as 1
        write_block(16'h0050, 2, 1, 4'd0);
        wait_drain(100);

        // 4: DEPTH words without s_last, then next beat lands in bank1
        write_block(16'h4000, DEPTH, 0, 4'd1);
        s_valid = 1'b1; s_data = 16'h4FFF; s_last = 1'b1; s_repeats = 4'd1;
        q.push_back({1'b1, 16'h4FFF});
        @(negedge clk);
        chk(s_ready == 1'b1, "forced_end_s_ready", s_ready, 1);
        chk(ram_we == 2'b10, "forced_end_bank1_we", ram_we, 2);
        chk(ram_addr[2*AW-1:AW] == '0, "forced_end_bank1_addr", ram_addr[2*AW-1:AW], 0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        wait_drain(300);

        // 6: reset during readout of word 5
        write_block(16'h6000, 8, 1, 4'd1);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (q.size() == 3) hit = 1;
        end
        chk(hit, "reach_word5", q.size(), 3);
        #2;
        rstn = 1'b0;
        #1;
        chk(m_valid == 1'b0, "async_rst_m_valid", m_valid, 0);
        chk(ram_en == 2'b00, "async_rst_ram_en", ram_en, 0);
        chk(busy == 2'b00, "async_rst_busy", busy, 0);
        chk(s_ready == 1'b0, "async_rst_s_ready", s_ready, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b1; s_data = 16'h7777; s_last = 1'b1; s_repeats = 4'd0;
        q.push_back({1'b1, 16'h7777});
        @(negedge clk);
        chk(s_ready == 1'b1, "after_rst_s_ready", s_ready, 1);
        chk(ram_we == 2'b01, "after_rst_bank0_we", ram_we, 1);
        chk(ram_addr[AW-1:0] == '0, "after_rst_addr", ram_addr[AW-1:0], 0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        wait_drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
